// File: rtl/delay_sched_pkg.sv
// Shared definitions for the pulse delay scheduler.
// Holds parameter defaults, the FSM state type and the minimum delay.
package delay_sched_pkg;

    localparam int DELAY_W_DEF = 16;
    localparam int DEPTH_DEF   = 8;
    localparam int MIN_DELAY   = 1;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_e;

endpackage

// File: rtl/due_fifo.sv
// Synchronous FIFO of due timestamps for the delay scheduler.
// A push into a full FIFO is accepted only with a same-cycle pop.
module due_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/pulse_delay_scheduler.sv
// Replays each sampled-high cycle of sig exactly D cycles later,
// with up to DEPTH events in flight, timestamped against a wrapping counter.
module pulse_delay_scheduler
    import delay_sched_pkg::*;
#(
    parameter int DELAY_W = DELAY_W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sig,
    input  logic [DELAY_W-1:0] delay_cfg,
    input  logic               cfg_we,
    input  logic               err_clr,
    output logic               delayed_sig,
    output logic               busy,
    output logic [CNT_W-1:0]   pending,
    output logic               overflow,
    output logic               cfg_err
);

    logic [DELAY_W-1:0] now_q, now_d;
    logic [DELAY_W-1:0] delay_q, delay_d;
    logic               dly_q, dly_d;
    logic               ovf_q, ovf_d;
    logic               cerr_q, cerr_d;
    state_e             state_q, state_d;

    logic [DELAY_W-1:0] head;
    logic               full;
    logic               empty;
    logic [CNT_W-1:0]   count;
    logic               push;
    logic               pop;
    logic               idle_q;

    // Due times are unique and monotonic, so equality with now is wrap-safe.
    assign pop    = !empty && (head == now_q);
    assign push   = sig && (!full || pop);
    assign idle_q = (count == '0);

    due_fifo #(
        .WIDTH (DELAY_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (now_q + delay_q),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        now_d   = now_q + DELAY_W'(1);
        delay_d = delay_q;
        dly_d   = pop;
        ovf_d   = (sig && full && !pop) || (ovf_q && !err_clr);
        cerr_d  = (cfg_we && !idle_q) || (cerr_q && !err_clr);
        state_d = state_q;
        if (cfg_we && idle_q) begin
            delay_d = (delay_cfg == '0) ? DELAY_W'(MIN_DELAY) : delay_cfg;
        end
        unique case (state_q)
            ST_IDLE: if (push) state_d = ST_RUN;
            ST_RUN: begin
                if (pop && !push && count == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            now_q   <= '0;
            delay_q <= DELAY_W'(MIN_DELAY);
            dly_q   <= 1'b0;
            ovf_q   <= 1'b0;
            cerr_q  <= 1'b0;
            state_q <= ST_IDLE;
        end else begin
            now_q   <= now_d;
            delay_q <= delay_d;
            dly_q   <= dly_d;
            ovf_q   <= ovf_d;
            cerr_q  <= cerr_d;
            state_q <= state_d;
        end
    end

    assign delayed_sig = dly_q;
    assign busy        = (state_q == ST_RUN);
    assign pending     = count;
    assign overflow    = ovf_q;
    assign cfg_err     = cerr_q;

endmodule

// File: tb/tb_pulse_delay_scheduler.sv
// Randomised and directed bench for pulse_delay_scheduler against a
// queue-of-absolute-due-cycles reference model.
module tb_pulse_delay_scheduler;

    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sig, cfg_we, err_clr;
    logic [15:0] delay_cfg;
    logic        delayed_sig, busy, overflow, cfg_err;
    logic [CW-1:0] pending;

    logic        sig4, cfg_we4, err_clr4;
    logic [3:0]  delay_cfg4;
    logic        dsig4, busy4, ovf4, cerr4;
    logic [CW-1:0] pend4;

    int n_checks = 0;
    int n_fail   = 0;

    int cyc;
    int mq[$];
    int pulses[$];
    int m_delay;
    bit m_ovf, m_cerr, m_dsig;

    always #5 clk = ~clk;

    pulse_delay_scheduler #(.DELAY_W(16), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .sig(sig), .delay_cfg(delay_cfg),
        .cfg_we(cfg_we), .err_clr(err_clr), .delayed_sig(delayed_sig),
        .busy(busy), .pending(pending), .overflow(overflow),
        .cfg_err(cfg_err)
    );

    pulse_delay_scheduler #(.DELAY_W(4), .DEPTH(DEPTH)) dut4 (
        .clk(clk), .rst_n(rst_n), .sig(sig4), .delay_cfg(delay_cfg4),
        .cfg_we(cfg_we4), .err_clr(err_clr4), .delayed_sig(dsig4),
        .busy(busy4), .pending(pend4), .overflow(ovf4),
        .cfg_err(cerr4)
    );

    // One clock edge: model predicts, DUT steps, outputs compared #1 later.
    task automatic tick(input bit s, input bit we, input int cfg,
                        input bit clr);
        int  pre;
        bit  p, acc;
        sig       = s;
        cfg_we    = we;
        delay_cfg = 16'(cfg);
        err_clr   = clr;
        pre = mq.size();
        p = 1'b0;
        if (pre > 0) p = (mq[0] == cyc);
        acc    = s && (pre < DEPTH || p);
        m_ovf  = (s && pre == DEPTH && !p) || (m_ovf && !clr);
        m_cerr = (we && pre != 0) || (m_cerr && !clr);
        if (p) void'(mq.pop_front());
        if (acc) mq.push_back(cyc + m_delay);
        if (we && pre == 0) m_delay = (cfg == 0) ? 1 : cfg;
        m_dsig = p;
        @(posedge clk);
        #1;
        cyc++;
        if (delayed_sig) pulses.push_back(cyc - 1);
        n_checks += 5;
        if (delayed_sig !== m_dsig) begin
            n_fail++;
            $display("FAIL delayed_sig edge=%0d got %b exp %b",
                     cyc - 1, delayed_sig, m_dsig);
        end
        if (pending !== CW'(mq.size())) begin
            n_fail++;
            $display("FAIL pending edge=%0d got %0d exp %0d",
                     cyc - 1, pending, mq.size());
        end
        if (busy !== (mq.size() != 0)) begin
            n_fail++;
            $display("FAIL busy edge=%0d got %b exp %b",
                     cyc - 1, busy, mq.size() != 0);
        end
        if (overflow !== m_ovf) begin
            n_fail++;
            $display("FAIL overflow edge=%0d got %b exp %b",
                     cyc - 1, overflow, m_ovf);
        end
        if (cfg_err !== m_cerr) begin
            n_fail++;
            $display("FAIL cfg_err edge=%0d got %b exp %b",
                     cyc - 1, cfg_err, m_cerr);
        end
    endtask

    task automatic do_reset();
        sig = 0; cfg_we = 0; err_clr = 0; delay_cfg = '0;
        sig4 = 0; cfg_we4 = 0; err_clr4 = 0; delay_cfg4 = '0;
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({delayed_sig, busy, pending, overflow, cfg_err} !== '0 ||
            {dsig4, busy4, pend4} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got ds=%b b=%b p=%0d o=%b c=%b exp all 0",
                     delayed_sig, busy, pending, overflow, cfg_err);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        mq.delete();
        pulses.delete();
        m_delay = 1;
        m_ovf = 0; m_cerr = 0; m_dsig = 0;
    endtask

    task automatic test_reset();
        do_reset();
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
    endtask

    task automatic test_single();
        do_reset();
        tick(0, 1, 5, 0);
        while (cyc < 10) tick(0, 0, 0, 0);
        tick(1, 0, 0, 0);
        repeat (12) tick(0, 0, 0, 0);
        n_checks++;
        if (pulses.size() != 1 || pulses[0] != 15) begin
            n_fail++;
            $display("FAIL single_latency got %0d pulses (first %0d) exp 1 at 15",
                     pulses.size(), pulses.size() ? pulses[0] : -1);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        tick(0, 1, 20, 0);
        repeat (10) tick(1, 0, 0, 0);
        repeat (40) tick(0, 0, 0, 0);
        n_checks++;
        if (pulses.size() != 8 || pulses[0] != 21 || pulses[7] != 28) begin
            n_fail++;
            $display("FAIL overflow_pulses got %0d pulses exp 8 at 21..28",
                     pulses.size());
        end
        n_checks++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_sticky got %b exp 1", overflow);
        end
        tick(0, 0, 0, 1);
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_clear got %b exp 0", overflow);
        end
    endtask

    task automatic test_cfg_err();
        int e;
        do_reset();
        tick(0, 1, 6, 0);
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        tick(0, 1, 3, 0);
        n_checks++;
        if (cfg_err !== 1'b1) begin
            n_fail++;
            $display("FAIL cfg_err_set got %b exp 1", cfg_err);
        end
        repeat (10) tick(0, 0, 0, 0);
        pulses.delete();
        e = cyc;
        tick(1, 0, 0, 0);
        repeat (8) tick(0, 0, 0, 0);
        n_checks++;
        if (pulses.size() != 1 || pulses[0] != e + 6) begin
            n_fail++;
            $display("FAIL cfg_rejected_delay got %0d pulses exp 1 at %0d",
                     pulses.size(), e + 6);
        end
        tick(0, 0, 0, 1);
        tick(0, 1, 0, 0);
        pulses.delete();
        e = cyc;
        tick(1, 0, 0, 0);
        repeat (3) tick(0, 0, 0, 0);
        n_checks++;
        if (pulses.size() != 1 || pulses[0] != e + 1) begin
            n_fail++;
            $display("FAIL cfg_zero_delay got %0d pulses exp 1 at %0d",
                     pulses.size(), e + 1);
        end
    endtask

    task automatic test_d1_stream();
        do_reset();
        repeat (20) tick(1, 0, 0, 0);
        repeat (3) tick(0, 0, 0, 0);
        n_checks++;
        if (pulses.size() != 20 || pulses[0] != 1 || pulses[19] != 20 ||
            overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL d1_stream got %0d pulses ovf=%b exp 20 at 1..20 ovf=0",
                     pulses.size(), overflow);
        end
    endtask

    task automatic test_wrap();
        int  e, np;
        bit  exp_ds;
        do_reset();
        cfg_we4    = 1'b1;
        delay_cfg4 = 4'hF;
        tick(0, 0, 0, 0);
        cfg_we4 = 1'b0;
        for (int k = 1; k < 40; k++) begin
            e = cyc;
            sig4 = (e == 14 || e == 15 || e == 16);
            tick(0, 0, 0, 0);
            exp_ds = (e == 29 || e == 30 || e == 31);
            np = 0;
            for (int t = 14; t <= 16; t++) begin
                if (t <= e && t + 15 > e) np++;
            end
            n_checks += 3;
            if (dsig4 !== exp_ds) begin
                n_fail++;
                $display("FAIL wrap_delayed edge=%0d got %b exp %b", e, dsig4, exp_ds);
            end
            if (pend4 !== CW'(np)) begin
                n_fail++;
                $display("FAIL wrap_pending edge=%0d got %0d exp %0d", e, pend4, np);
            end
            if (busy4 !== (np != 0)) begin
                n_fail++;
                $display("FAIL wrap_busy edge=%0d got %b exp %b", e, busy4, np != 0);
            end
        end
        sig4 = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        tick(0, 1, 8, 0);
        repeat (3) tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        n_checks++;
        if (pending !== CW'(3)) begin
            n_fail++;
            $display("FAIL pre_reset_pending got %0d exp 3", pending);
        end
        do_reset();
        repeat (20) tick(0, 0, 0, 0);
        n_checks++;
        if (pulses.size() != 0) begin
            n_fail++;
            $display("FAIL post_reset_pulses got %0d exp 0", pulses.size());
        end
    endtask

    task automatic test_random();
        do_reset();
        repeat (600) begin
            tick($urandom_range(0, 99) < 45,
                 $urandom_range(0, 19) == 0,
                 int'($urandom_range(0, 12)),
                 $urandom_range(0, 15) == 0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_single();
        test_overflow();
        test_cfg_err();
        test_d1_stream();
        test_wrap();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
